// File: rtl/alu_logical_bist_if.sv
// Operand/opcode/result bus between the logical-slice BIST and the slice.
// The BIST is the master (drives operands/selects), the slice the slave.
interface alu_logical_bist_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic        in_and;
  logic        in_or;
  logic        in_neg;
  logic        in_not;

  modport master (
    output a, b, in_and, in_or, in_neg, in_not,
    input  c
  );

  modport slave (
    input  a, b, in_and, in_or, in_neg, in_not,
    output c
  );
endinterface

// File: rtl/alu_logical_bist.sv
// BIST driver for the logical ALU slice: LFSR operands, one-hot op, check c.
// Optional failure capture registers enabled by ALU_BIST_CAPTURE_EN.
module alu_logical_bist #(
  parameter int unsigned VECTORS = 1000,
  parameter logic [63:0] SEED    = 64'h1
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 start,
  alu_logical_bist_if.master   alu,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [1:0]           fail_op,
  output logic [15:0]          fail_index
`ifdef ALU_BIST_CAPTURE_EN
  ,
  output logic [31:0]          fail_a,
  output logic [31:0]          fail_b,
  output logic [31:0]          fail_c,
  output logic [31:0]          fail_exp
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [15:0] LAST = 16'(VECTORS - 1);

  state_t      state, state_d;
  logic [63:0] lfsr, lfsr_d, lfsr_nxt;
  logic [1:0]  op, op_d;
  logic [15:0] idx, idx_d;
  logic [1:0]  fail_op_d;
  logic [15:0] fail_index_d;
  logic [31:0] exp_c;
  logic        match;
  logic        start_ok;
  logic        chk_bad;

  assign alu.a = lfsr[31:0];
  assign alu.b = lfsr[63:32];

  assign busy = (state == S_DRIVE) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign fail = (state == S_FAIL);

  assign alu.in_and = busy && (op == 2'd0);
  assign alu.in_or  = busy && (op == 2'd1);
  assign alu.in_neg = busy && (op == 2'd2);
  assign alu.in_not = busy && (op == 2'd3);

  assign lfsr_nxt = {lfsr[62:0],
                     ~(lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59])};

  assign start_ok = start &&
                    ((state == S_IDLE) || (state == S_DONE) ||
                     (state == S_FAIL));

  assign match   = (alu.c == exp_c);
  assign chk_bad = (state == S_CHECK) && !match;

  // Reference result for the op currently applied to the slice
  always_comb begin
    exp_c = '0;
    unique case (op)
      2'd0: exp_c = alu.a & alu.b;
      2'd1: exp_c = alu.a | alu.b;
      2'd2: exp_c = ~alu.a + 32'd1;
      2'd3: exp_c = ~alu.a;
    endcase
  end

  // Next-state, vector sequencing and failure capture
  always_comb begin
    state_d      = state;
    lfsr_d       = lfsr;
    op_d         = op;
    idx_d        = idx;
    fail_op_d    = fail_op;
    fail_index_d = fail_index;
    unique case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d      = S_DRIVE;
          lfsr_d       = SEED;
          op_d         = '0;
          idx_d        = '0;
          fail_op_d    = '0;
          fail_index_d = '0;
        end
      end
      S_DRIVE: state_d = S_CHECK;
      S_CHECK: begin
        if (match) begin
          lfsr_d = lfsr_nxt;
          if (idx < LAST) begin
            idx_d   = idx + 16'd1;
            state_d = S_DRIVE;
          end else if (op != 2'd3) begin
            op_d    = op + 2'd1;
            idx_d   = '0;
            state_d = S_DRIVE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          fail_op_d    = op;
          fail_index_d = idx;
          state_d      = S_FAIL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and sequencing registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= S_IDLE;
      lfsr       <= SEED;
      op         <= '0;
      idx        <= '0;
      fail_op    <= '0;
      fail_index <= '0;
    end else begin
      state      <= state_d;
      lfsr       <= lfsr_d;
      op         <= op_d;
      idx        <= idx_d;
      fail_op    <= fail_op_d;
      fail_index <= fail_index_d;
    end
  end

`ifdef ALU_BIST_CAPTURE_EN
  // Snapshot operands, observed and expected result on a mismatch
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      fail_a   <= '0;
      fail_b   <= '0;
      fail_c   <= '0;
      fail_exp <= '0;
    end else if (start_ok) begin
      fail_a   <= '0;
      fail_b   <= '0;
      fail_c   <= '0;
      fail_exp <= '0;
    end else if (chk_bad) begin
      fail_a   <= alu.a;
      fail_b   <= alu.b;
      fail_c   <= alu.c;
      fail_exp <= exp_c;
    end
  end
`else
  logic unused_cap;
  assign unused_cap = start_ok ^ chk_bad;
`endif

endmodule

// File: tb/tb_alu_logical_bist.sv
// Testbench for alu_logical_bist: slice model, fault injection,
// LFSR sequence reference and status checks.
module tb_alu_logical_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_n;
  logic start;
  logic start1;
  logic or_stuck;
  logic [31:0] flip;

  int total = 0;
  int bad   = 0;

  alu_logical_bist_if bus4 ();
  alu_logical_bist_if bus1 ();

  logic        busy4, done4, fail4;
  logic [1:0]  fop4;
  logic [15:0] fidx4;
  logic        busy1, done1, fail1;
  logic [1:0]  fop1;
  logic [15:0] fidx1;
`ifdef ALU_BIST_CAPTURE_EN
  logic [31:0] fa4, fb4, fc4, fe4;
  logic [31:0] fa1, fb1, fc1, fe1;
`endif

  alu_logical_bist #(.VECTORS(4), .SEED(64'h1)) u4 (
    .clk(clk), .clr_n(clr_n), .start(start), .alu(bus4),
    .busy(busy4), .done(done4), .fail(fail4),
    .fail_op(fop4), .fail_index(fidx4)
`ifdef ALU_BIST_CAPTURE_EN
    , .fail_a(fa4), .fail_b(fb4), .fail_c(fc4), .fail_exp(fe4)
`endif
  );

  alu_logical_bist #(.VECTORS(1), .SEED(64'h1)) u1 (
    .clk(clk), .clr_n(clr_n), .start(start1), .alu(bus1),
    .busy(busy1), .done(done1), .fail(fail1),
    .fail_op(fop1), .fail_index(fidx1)
`ifdef ALU_BIST_CAPTURE_EN
    , .fail_a(fa1), .fail_b(fb1), .fail_c(fc1), .fail_exp(fe1)
`endif
  );

  // Behavioural slice with optional faults
  logic [31:0] c4, c1;
  always_comb begin
    c4 = '0;
    if (bus4.in_and) c4 = bus4.a & bus4.b;
    if (bus4.in_or)  c4 = bus4.a | bus4.b;
    if (bus4.in_neg) c4 = -bus4.a;
    if (bus4.in_not) c4 = ~bus4.a;
    if (or_stuck && bus4.in_or) c4[0] = 1'b0;
    c4 = c4 ^ flip;
  end
  assign bus4.c = c4;

  always_comb begin
    c1 = '0;
    if (bus1.in_and) c1 = bus1.a & bus1.b;
    if (bus1.in_or)  c1 = bus1.a | bus1.b;
    if (bus1.in_neg) c1 = -bus1.a;
    if (bus1.in_not) c1 = ~bus1.a;
  end
  assign bus1.c = c1;

  function automatic logic [63:0] step(input logic [63:0] s);
    return {s[62:0], ~(s[63] ^ s[62] ^ s[60] ^ s[59])};
  endfunction

  function automatic logic [31:0] ref_c(input int op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return 32'(0 - a);
      default: return ~a;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] seq [0:16];
  logic [3:0]  sel4;
  assign sel4 = {bus4.in_and, bus4.in_or, bus4.in_neg, bus4.in_not};

  initial begin
    int tgt;
    logic [31:0] mask;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ex;

    seq[0] = 64'h1;
    for (int i = 1; i <= 16; i++) seq[i] = step(seq[i-1]);

    clr_n = 1'b0; start = 1'b0; start1 = 1'b0;
    or_stuck = 1'b0; flip = '0;
    repeat (2) tick();

    // reset state
    chk("rst_a", bus4.a, 64'h1);
    chk("rst_b", bus4.b, 64'h0);
    chk("rst_sel", sel4, 4'b0);
    chk("rst_stat", {busy4, done4, fail4}, 3'b000);
    chk("rst_fop", fop4, 2'd0);
    chk("rst_fidx", fidx4, 16'd0);
    clr_n = 1'b1;
    tick();

    // full pass, random start noise while busy
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("drv_a", bus4.a, seq[k][31:0]);
      chk("drv_b", bus4.b, seq[k][63:32]);
      chk("drv_sel", sel4, 4'b1000 >> (k / 4));
      chk("drv_busy", busy4, 1'b1);
      if (k == 8) begin
        chk("neg8_a", bus4.a, 32'h000001FF);
        chk("neg8_c", bus4.c, 32'hFFFFFE01);
      end
      if (k == 0) chk("v0_c", bus4.c, 32'h0);
      start = 1'($urandom_range(0, 1));
      tick();
      chk("chk_sel", sel4, 4'b1000 >> (k / 4));
      chk("chk_busy", busy4, 1'b1);
      start = (k < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    chk("pass_stat", {busy4, done4, fail4}, 3'b010);
    chk("pass_sel", sel4, 4'b0);
    chk("pass_a", bus4.a, seq[16][31:0]);
    chk("pass_fop", fop4, 2'd0);
    repeat (3) tick();
    chk("hold_done", done4, 1'b1);

    // OR bit0 stuck at 0 -> fails at OR index 0
    or_stuck = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_done_drop", done4, 1'b0);
    repeat (9) tick();
    chk("or_prefail", {busy4, fail4}, 2'b10);
    tick();
    chk("or_fail", {busy4, done4, fail4}, 3'b001);
    chk("or_fop", fop4, 2'd1);
    chk("or_fidx", fidx4, 16'd0);
    chk("or_a_hold", bus4.a, seq[4][31:0]);
`ifdef ALU_BIST_CAPTURE_EN
    ex = seq[4][31:0] | seq[4][63:32];
    chk("or_cap_a", fa4, seq[4][31:0]);
    chk("or_cap_b", fb4, seq[4][63:32]);
    chk("or_cap_exp", fe4, ex);
    chk("or_cap_c", fc4, ex & ~32'h1);
`endif
    or_stuck = 1'b0;

    // random vector corrupted by a random nonzero mask
    tgt  = int'($urandom_range(0, 15));
    mask = $urandom | 32'h1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rnd_clr_fail", fail4, 1'b0);
    for (int k = 0; k <= tgt; k++) begin
      if (k == tgt) flip = mask;
      tick();
      tick();
    end
    flip = '0;
    chk("rnd_fail", {busy4, done4, fail4}, 3'b001);
    chk("rnd_fop", fop4, 2'(tgt / 4));
    chk("rnd_fidx", fidx4, 16'(tgt % 4));
    chk("rnd_a_hold", bus4.a, seq[tgt][31:0]);
`ifdef ALU_BIST_CAPTURE_EN
    ea = seq[tgt][31:0];
    eb = seq[tgt][63:32];
    ex = ref_c(tgt / 4, ea, eb);
    chk("rnd_cap_a", fa4, ea);
    chk("rnd_cap_exp", fe4, ex);
    chk("rnd_cap_c", fc4, ex ^ mask);
`else
    ea = '0; eb = '0; ex = '0;
`endif

    // restart from FAIL, then async reset mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("re_stat", {busy4, done4, fail4}, 3'b100);
    chk("re_a", bus4.a, seq[0][31:0]);
    repeat (4) tick();
    chk("mid_a", bus4.a, seq[2][31:0]);
    #2 clr_n = 1'b0;
    #1;
    chk("ar_stat", {busy4, done4, fail4}, 3'b000);
    chk("ar_sel", sel4, 4'b0);
    chk("ar_a", bus4.a, 64'h1);
    chk("ar_fidx", {fop4, fidx4}, 18'd0);
    tick();
    clr_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (31) tick();
    chk("ar_pre_done", done4, 1'b0);
    tick();
    chk("ar_done", {busy4, done4, fail4}, 3'b010);

    // start held high: one pass, then immediate restart
    start = 1'b1;
    tick();
    repeat (31) tick();
    chk("hold_pre", done4, 1'b0);
    tick();
    chk("hold_done1", {busy4, done4}, 2'b01);
    tick();
    chk("hold_restart", {busy4, done4}, 2'b10);
    chk("hold_reseed", bus4.a, seq[0][31:0]);
    start = 1'b0;
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    tick();

    // VECTORS=1: done exactly 8 cycles after accept, busy starts ignored
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      start1 = (i == 3 || i == 5);
      tick();
    end
    start1 = 1'b0;
    chk("v1_pre", {busy1, done1}, 2'b10);
    tick();
    chk("v1_done", {busy1, done1, fail1}, 3'b010);
    chk("v1_a", bus1.a, seq[4][31:0]);
    chk("v1_b", bus1.b, seq[4][63:32]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
